recepcao_medida: RTL and testbench
==================================

RECEPCAO_MEDIDA -- requirements
Module: recepcao_medida

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate of the measurement link.
REQ-003 Parameter TIMEOUT_CYCLES, default 500000, maximum idle clocks allowed before each frame byte (10 ms at 50 MHz).
REQ-004 clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 receber  input  1  synchronous request to arm reception of one frame.
REQ-007 rx_serial  input  1  8N1 serial line from the DHT11 bridge, idle high.
REQ-008 temperatura  output  16  {temp_int, temp_dec} of the last valid frame.
REQ-009 umidade  output  16  {hum_int, hum_dec} of the last valid frame.
REQ-010 pronto  output  1  one-cycle pulse when a frame has been accepted or rejected.
REQ-011 erro  output  1  level; high when the last frame failed checksum, framing or timeout.
REQ-012 db_estado  output  3  current FSM state code.

Function
REQ-013 rx_serial SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Byte receiver SHALL detect a start bit on a falling edge, resample it at half a bit period (CLK_FREQ/BAUD/2 clocks), and reject it as a glitch if high.
REQ-015 Byte receiver SHALL sample 8 data bits LSB first, one bit period apart, then the stop bit; stop bit low flags a framing error.
REQ-016 Byte receiver SHALL pulse byte_ok or byte_err for exactly one clock after the stop-bit sample.
REQ-017 Frame order SHALL be hum_int, hum_dec, temp_int, temp_dec, checksum (5 bytes).
REQ-018 FSM states and codes: INICIAL=0, ESPERA=1, ARMAZENA=2, VERIFICA=3, PRONTO=4, ERRO=5.
REQ-019 INICIAL -> ESPERA when receber=1; byte index and timeout counter cleared; bytes arriving in INICIAL are ignored.
REQ-020 ESPERA -> ARMAZENA on byte_ok; ESPERA -> ERRO on byte_err or timeout counter reaching TIMEOUT_CYCLES-1.
REQ-021 Timeout counter SHALL count in ESPERA only while no byte is in progress and clear on each byte_ok.
REQ-022 ARMAZENA stores the byte in the slot given by the index; increments the index; -> ESPERA if index<4, else -> VERIFICA (1 clock).
REQ-023 VERIFICA: (sum of bytes 0..3) mod 256 == byte 4 -> PRONTO, else -> ERRO (1 clock).
REQ-024 PRONTO: load temperatura/umidade from the stored bytes, clear erro, pulse pronto, -> INICIAL.
REQ-025 ERRO: set erro, pulse pronto, leave temperatura/umidade unchanged, -> INICIAL.
REQ-026 pronto SHALL be registered, asserted in the clock after entry to PRONTO or ERRO, never two consecutive cycles.
REQ-027 receber asserted outside INICIAL SHALL be ignored; a frame in progress is not restarted.
REQ-028 Latency: pronto SHALL rise within 4 clocks after the byte_ok of the checksum byte.
REQ-029 Checksum sum SHALL be computed in 8 bits with carries discarded (wrap-around).

Reset
REQ-030 Reset low SHALL force state INICIAL, temperatura=0, umidade=0, pronto=0, erro=0, db_estado=0, byte receiver idle, all counters and stored bytes cleared, immediately and regardless of clock.
REQ-031 Reset mid-frame SHALL discard partial bytes; after release, a new receber is required.

Structure
REQ-032 State codes, frame length (5) and the bit-period expression SHALL live in a shared package used by the top-level debug decoding.
REQ-033 The 8N1 receiver SHALL be a sub-module named uart_rx_8n1 (ports clock, reset, rx, dado[7:0], byte_ok, byte_err).

Verification
REQ-034 receber, frame 0x37,0x00,0x19,0x05,0x55 -> one pronto pulse, umidade=0x3700, temperatura=0x1905, erro=0.
REQ-035 Frame 0x37,0x00,0x19,0x05,0x56 -> pronto pulse, erro=1, outputs retain prior values.
REQ-036 Frame 0xFF,0xFF,0x01,0x01,0x00 -> wrap-around sum 0x00 matches, erro=0, temperatura=0x0101.
REQ-037 receber, 2 bytes then line idle 10 ms -> erro=1, pronto pulse, db_estado back to 0.
REQ-038 Third byte with stop bit low -> erro=1; 50 ns low glitch on rx -> no byte accepted.
REQ-039 Reset low during byte 3, release, full valid frame without receber -> no pronto; with receber -> valid result.

Source files
------------

// File: rtl/recepcao_medida_pkg.sv
// Shared definitions for the DHT11 measurement receiver: FSM state codes,
// frame geometry, serial bit timing and the frame checksum.
package recepcao_medida_pkg;

  // Frame FSM state codes; these values are exposed on db_estado
  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    ESPERA   = 3'd1,
    ARMAZENA = 3'd2,
    VERIFICA = 3'd3,
    PRONTO   = 3'd4,
    ERRO     = 3'd5
  } estado_t;

  // Byte receiver phases
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_estado_t;

  // hum_int, hum_dec, temp_int, temp_dec, checksum
  localparam int FRAME_LEN = 5;
  localparam int IDX_W     = 3;

  // Clocks per serial bit
  function automatic int bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // 8-bit wrap-around sum of every byte except the trailing checksum
  function automatic logic [7:0] soma8(input logic [FRAME_LEN-1:0][7:0] b);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < FRAME_LEN-1; i++) s = s + b[i];
    return s;
  endfunction

endpackage

// File: rtl/recepcao_medida_if.sv
// Request/serial/result signals of the measurement receiver.
interface recepcao_medida_if;
  logic        receber;
  logic        rx_serial;
  logic [15:0] temperatura;
  logic [15:0] umidade;
  logic        pronto;
  logic        erro;
  logic [2:0]  db_estado;

  // Requester side: arms reception and drives the line, reads results
  modport master (
    output receber, rx_serial,
    input  temperatura, umidade, pronto, erro, db_estado
  );

  // Receiver side
  modport slave (
    input  receber, rx_serial,
    output temperatura, umidade, pronto, erro, db_estado
  );
endinterface

// File: rtl/recepcao_medida_uart_rx.sv
// 8N1 byte receiver. Expects an already-synchronized rx. Start bit is
// confirmed at mid-bit, data is sampled LSB first every bit period, and a
// one-clock byte_ok/byte_err pulse follows the stop-bit sample. ocupado is
// high from start-bit detection until the stop bit has been sampled.
module uart_rx_8n1
  import recepcao_medida_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dado,
  output logic       byte_ok,
  output logic       byte_err,
  output logic       ocupado
);

  localparam int BIT  = bit_period(CLK_FREQ, BAUD);
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT + 1);

  rx_estado_t   r_st;
  logic         r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]   r_nbit;
  logic [7:0]   r_dado;
  logic         r_ok;
  logic         r_err;

  // Bit-timing state machine: edge detect, mid-bit sampling, stop check
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st   <= RX_IDLE;
      r_prev <= 1'b1;
      r_cnt  <= '0;
      r_nbit <= '0;
      r_dado <= '0;
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_prev <= rx;
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
      case (r_st)
        RX_IDLE: begin
          if (r_prev && !rx) begin
            r_st  <= RX_START;
            r_cnt <= CW'(HALF - 1);
          end
        end
        RX_START: begin
          if (r_cnt == '0) begin
            // line back high at mid start bit: treat as a glitch
            if (rx) begin
              r_st <= RX_IDLE;
            end else begin
              r_st   <= RX_DATA;
              r_cnt  <= CW'(BIT - 1);
              r_nbit <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == '0) begin
            r_dado <= {rx, r_dado[7:1]};
            r_cnt  <= CW'(BIT - 1);
            if (r_nbit == 3'd7) r_st <= RX_STOP;
            else                r_nbit <= r_nbit + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == '0) begin
            r_ok  <= rx;
            r_err <= !rx;
            r_st  <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_st <= RX_IDLE;
      endcase
    end
  end

  assign dado     = r_dado;
  assign byte_ok  = r_ok;
  assign byte_err = r_err;
  assign ocupado  = (r_st != RX_IDLE);

endmodule

// File: rtl/recepcao_medida.sv
// DHT11 measurement frame receiver: on request, collects five bytes from
// the serial bridge, verifies the 8-bit checksum and publishes humidity and
// temperature, or flags an error on checksum, framing or inter-byte timeout.
module recepcao_medida
  import recepcao_medida_pkg::*;
#(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = 9600,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             reset,
  recepcao_medida_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]                r_sync;
  logic                      w_rx;
  logic [7:0]                w_dado;
  logic                      w_byte_ok;
  logic                      w_byte_err;
  logic                      w_ocupado;

  estado_t                   r_estado;
  logic [IDX_W-1:0]          r_idx;
  logic [TW-1:0]             r_tmo;
  logic [FRAME_LEN-1:0][7:0] r_bytes;
  logic [15:0]               r_temp;
  logic [15:0]               r_umid;
  logic                      r_pronto;
  logic                      r_erro;

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], bus.rx_serial};
  end
  assign w_rx = r_sync[1];

  uart_rx_8n1 #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clock    (clock),
    .reset    (reset),
    .rx       (w_rx),
    .dado     (w_dado),
    .byte_ok  (w_byte_ok),
    .byte_err (w_byte_err),
    .ocupado  (w_ocupado)
  );

  // Frame FSM with registered results; pronto lands one clock after
  // PRONTO/ERRO, by which time the FSM is already back in INICIAL
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
      r_idx    <= '0;
      r_tmo    <= '0;
      r_bytes  <= '0;
      r_temp   <= '0;
      r_umid   <= '0;
      r_pronto <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      case (r_estado)
        INICIAL: begin
          if (bus.receber) begin
            r_estado <= ESPERA;
            r_idx    <= '0;
            r_tmo    <= '0;
          end
        end
        ESPERA: begin
          if (w_byte_ok) begin
            r_estado <= ARMAZENA;
            r_tmo    <= '0;
          end else if (w_byte_err) begin
            r_estado <= ERRO;
          end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            r_estado <= ERRO;
          end else if (!w_ocupado) begin
            // only idle line time counts toward the timeout
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ARMAZENA: begin
          r_bytes[r_idx] <= w_dado;
          r_idx          <= r_idx + 1'b1;
          if (r_idx < IDX_W'(FRAME_LEN - 1)) r_estado <= ESPERA;
          else                               r_estado <= VERIFICA;
        end
        VERIFICA: begin
          if (soma8(r_bytes) == r_bytes[FRAME_LEN-1]) r_estado <= PRONTO;
          else                                        r_estado <= ERRO;
        end
        PRONTO: begin
          r_umid   <= {r_bytes[0], r_bytes[1]};
          r_temp   <= {r_bytes[2], r_bytes[3]};
          r_erro   <= 1'b0;
          r_pronto <= 1'b1;
          r_estado <= INICIAL;
        end
        ERRO: begin
          r_erro   <= 1'b1;
          r_pronto <= 1'b1;
          r_estado <= INICIAL;
        end
        default: r_estado <= INICIAL;
      endcase
    end
  end

  assign bus.temperatura = r_temp;
  assign bus.umidade     = r_umid;
  assign bus.pronto      = r_pronto;
  assign bus.erro        = r_erro;
  assign bus.db_estado   = r_estado;

endmodule

// File: tb/tb_recepcao_medida.sv
// Bench for recepcao_medida: directed serial frames, a frame-level model of
// the expected results, and a per-cycle checker of the idle-time outputs.
module tb_recepcao_medida;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 3_125_000;
  localparam int TMO      = 500;
  localparam int BITC     = CLK_FREQ / BAUD;  // 16 clocks per bit

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  recepcao_medida_if bus();

  recepcao_medida #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD           (BAUD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int pulses      = 0;
  int last_pronto = 0;
  int stop_start  = 0;
  bit window      = 1'b1;
  logic prev_pronto = 1'b0;

  // model of the published results
  logic [15:0] m_temp = 16'h0;
  logic [15:0] m_umid = 16'h0;
  logic        m_erro = 1'b0;

  always @(posedge clk) cyc++;

  // Per-cycle checker: pronto never twice in a row; outside a frame window
  // the outputs must equal the model and the FSM must rest in state 0
  always @(negedge clk) begin
    if (bus.pronto) begin
      pulses++;
      last_pronto = cyc;
      vectors++;
      if (prev_pronto) begin
        miscompares++;
        $display("FAIL pronto_consecutive at cycle %0d: pronto high two cycles, required single pulse", cyc);
      end
    end
    prev_pronto = bus.pronto;
    if (!window) begin
      vectors++;
      if (bus.temperatura !== m_temp || bus.umidade !== m_umid || bus.erro !== m_erro ||
          bus.pronto !== 1'b0 || bus.db_estado !== 3'd0) begin
        miscompares++;
        $display("FAIL idle_outputs at cycle %0d: got temp=%h umid=%h erro=%b pronto=%b estado=%0d, required temp=%h umid=%h erro=%b pronto=0 estado=0",
                 cyc, bus.temperatura, bus.umidade, bus.erro, bus.pronto, bus.db_estado, m_temp, m_umid, m_erro);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    bus.rx_serial = v;
    repeat (BITC) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    stop_start = cyc;
    bit_out(stop_ok ? 1'b1 : 1'b0);
    bus.rx_serial = 1'b1;
    repeat (2*BITC) @(negedge clk);
  endtask

  task automatic pulse_receber();
    bus.receber = 1'b1;
    @(negedge clk);
    bus.receber = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One frame transaction plus the model's verdict on it
  task automatic frame(input string name, input logic [0:4][7:0] fr, input bit arm,
                       input int bad_stop, input int nsend, input int gap,
                       input bit mid_arm, input bit glitch);
    int p0;
    int s;
    bit bad;
    window = 1'b1;
    p0 = pulses;
    if (arm) pulse_receber();
    if (glitch) begin
      bus.rx_serial = 1'b0;
      #50;
      bus.rx_serial = 1'b1;
      repeat (3*BITC) @(negedge clk);
    end
    for (int i = 0; i < nsend; i++) begin
      send_byte(fr[i], i != bad_stop);
      if (mid_arm && i == 1) pulse_receber();
      repeat (gap) @(negedge clk);
    end
    if (nsend < 5) repeat (TMO + 100) @(negedge clk);
    else           repeat (30) @(negedge clk);
    if (arm) begin
      bad = (nsend < 5) || (bad_stop >= 0 && bad_stop < nsend);
      s = int'(fr[0]) + int'(fr[1]) + int'(fr[2]) + int'(fr[3]);
      if (bad || (s % 256) != int'(fr[4])) begin
        m_erro = 1'b1;
      end else begin
        m_umid = {fr[0], fr[1]};
        m_temp = {fr[2], fr[3]};
        m_erro = 1'b0;
      end
      chk({name, "_pulses"}, pulses - p0, 1);
      if (!bad) chk({name, "_latency_ok"}, int'((last_pronto - stop_start) >= 11 &&
                                              (last_pronto - stop_start) <= 15), 1);
    end else begin
      chk({name, "_pulses"}, pulses - p0, 0);
    end
    window = 1'b0;
  endtask

  initial begin
    bus.receber   = 1'b0;
    bus.rx_serial = 1'b1;
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_temperatura", int'(bus.temperatura), 0);
    chk("reset_umidade",     int'(bus.umidade), 0);
    chk("reset_pronto",      int'(bus.pronto), 0);
    chk("reset_erro",        int'(bus.erro), 0);
    chk("reset_estado",      int'(bus.db_estado), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    window = 1'b0;

    // valid frame
    frame("valid", {8'h37, 8'h00, 8'h19, 8'h05, 8'h55}, 1, -1, 5, 0, 0, 0);
    chk("valid_umidade",     int'(bus.umidade), 'h3700);
    chk("valid_temperatura", int'(bus.temperatura), 'h1905);
    chk("valid_erro",        int'(bus.erro), 0);

    // checksum mismatch: results retained
    frame("badsum", {8'h37, 8'h00, 8'h19, 8'h05, 8'h56}, 1, -1, 5, 0, 0, 0);
    chk("badsum_erro",        int'(bus.erro), 1);
    chk("badsum_temperatura", int'(bus.temperatura), 'h1905);

    // wrap-around checksum, with a stray receber mid-frame
    frame("wrap", {8'hFF, 8'hFF, 8'h01, 8'h01, 8'h00}, 1, -1, 5, 0, 1, 0);
    chk("wrap_temperatura", int'(bus.temperatura), 'h0101);
    chk("wrap_umidade",     int'(bus.umidade), 'hFFFF);
    chk("wrap_erro",        int'(bus.erro), 0);

    // two bytes then the line stays idle past the timeout
    frame("timeout", {8'h11, 8'h22, 8'h00, 8'h00, 8'h00}, 1, -1, 2, 0, 0, 0);
    chk("timeout_erro",   int'(bus.erro), 1);
    chk("timeout_estado", int'(bus.db_estado), 0);

    // third byte with a low stop bit
    frame("framing", {8'h12, 8'h34, 8'h56, 8'h78, 8'h14}, 1, 2, 5, 0, 0, 0);
    chk("framing_erro", int'(bus.erro), 1);

    // short low glitch before the frame must not become a byte
    frame("glitch", {8'h10, 8'h20, 8'h30, 8'h40, 8'hA0}, 1, -1, 5, 0, 0, 1);
    chk("glitch_temperatura", int'(bus.temperatura), 'h3040);
    chk("glitch_erro",        int'(bus.erro), 0);

    // long idle gaps between bytes, each shorter than the timeout
    frame("gaps", {8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 1, -1, 5, 400, 0, 0);
    chk("gaps_erro",    int'(bus.erro), 0);
    chk("gaps_umidade", int'(bus.umidade), 'h0102);

    // reset in the middle of the third byte
    window = 1'b1;
    pulse_receber();
    send_byte(8'h37, 1'b1);
    send_byte(8'h00, 1'b1);
    bus.rx_serial = 1'b0;
    repeat (3*BITC) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_temperatura", int'(bus.temperatura), 0);
    chk("midreset_umidade",     int'(bus.umidade), 0);
    chk("midreset_erro",        int'(bus.erro), 0);
    chk("midreset_estado",      int'(bus.db_estado), 0);
    m_temp = 16'h0;
    m_umid = 16'h0;
    m_erro = 1'b0;
    @(negedge clk);
    bus.rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    window = 1'b0;
    frame("noarm", {8'h37, 8'h00, 8'h19, 8'h05, 8'h55}, 0, -1, 5, 0, 0, 0);
    chk("noarm_temperatura", int'(bus.temperatura), 0);
    frame("rearm", {8'h22, 8'h33, 8'h44, 8'h55, 8'hEE}, 1, -1, 5, 0, 0, 0);
    chk("rearm_temperatura", int'(bus.temperatura), 'h4455);
    chk("rearm_umidade",     int'(bus.umidade), 'h2233);

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
